// File: rtl/operand_sequencer_if.sv
// Handshake bundle between the operand sequencer, the number-entry logic, the
// arithmetic datapath and the result consumer. master = sequencer side.
interface operand_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             num_valid;
  logic [WIDTH-1:0] num_data;
  logic             num_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_start;
  logic             op_done;
  logic [WIDTH-1:0] op_result;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;

  modport master (
    input  num_valid, num_data, op_done, op_result, res_ready,
    output num_ready, op_a, op_b, op_start, res_valid, res_data
  );

  modport slave (
    output num_valid, num_data, op_done, op_result, res_ready,
    input  num_ready, op_a, op_b, op_start, res_valid, res_data
  );
endinterface

// File: rtl/operand_sequencer.sv
// Collects operand A then B, launches the datapath, holds its result until taken.
// Optional datapath watchdog enabled by defining OPSEQ_TIMEOUT_EN.
module operand_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  operand_sequencer_if.master bus,
  output logic [1:0]          phase,
  output logic                err
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_WAIT_NUM1,
    S_WAIT_NUM2,
    S_START,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] op_a_q, op_b_q, res_data_q;
  logic             err_q;
  logic             accept, take_a, take_b, take_res, timed_out, expired;

`ifdef OPSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT_DONE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Expires in the WAIT_DONE cycle that would bring the count to TIMEOUT_CYCLES.
  assign expired = (state == S_WAIT_DONE) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  assign bus.num_ready = ((state == S_WAIT_NUM1) || (state == S_WAIT_NUM2)) && !clear;
  assign accept        = bus.num_valid && bus.num_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    take_a     = 1'b0;
    take_b     = 1'b0;
    take_res   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_WAIT_NUM1: if (accept) begin
        take_a     = 1'b1;
        next_state = S_WAIT_NUM2;
      end
      S_WAIT_NUM2: if (accept) begin
        take_b     = 1'b1;
        next_state = S_START;
      end
      S_START:     next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.op_done) begin
        take_res   = 1'b1;
        next_state = S_RESULT;
      end else if (expired) begin
        timed_out  = 1'b1;
        next_state = S_RESULT;
      end
      S_RESULT:    if (bus.res_ready) next_state = S_WAIT_NUM1;
      default:     next_state = S_WAIT_NUM1;
    endcase
    // Abort outranks everything, including a result arriving the same cycle.
    if (clear) begin
      next_state = S_WAIT_NUM1;
      take_res   = 1'b0;
      timed_out  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT_NUM1;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (take_a) op_a_q <= bus.num_data;
      if (take_b) op_b_q <= bus.num_data;
      if (take_res)       res_data_q <= bus.op_result;
      else if (timed_out) res_data_q <= '0;
      if (timed_out)                                err_q <= 1'b1;
      else if (take_res || next_state != S_RESULT)  err_q <= 1'b0;
    end
  end

  always_comb begin
    case (state)
      S_WAIT_NUM1: phase = 2'd0;
      S_WAIT_NUM2: phase = 2'd1;
      S_RESULT:    phase = 2'd3;
      default:     phase = 2'd2;
    endcase
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_start  = (state == S_START);
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = res_data_q;
  assign err           = err_q;

endmodule
